usb_tx_serializer: RTL and testbench

//  Parametrised USB transmit serializer: takes WORD_W-bit packet words over a valid/ready handshake,

---
 rtl/usb_tx_pkg.sv | 27 ++
 rtl/usb_tx_stuff_ctr.sv | 34 +++
 rtl/usb_tx_serializer.sv | 214 +++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and helpers for the USB transmit serializer.
package usb_tx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, CRC, FLUSH} tx_state_t;

  localparam int   STUFF_LIMIT = 6;
  localparam logic IDLE_BIT    = 1'b1;

  // Reorders a word so that bit 0 of the result is the first bit on the line.
  // Bytes are taken most-significant first when msb_byte_first is set,
  // bits inside each byte always go out LSB first.
  function automatic logic [63:0] bit_reorder(input logic [63:0] data,
                                              input int          width,
                                              input bit          msb_byte_first);
    logic [63:0] res;
    int          src;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        src    = msb_byte_first ? (width - 8 - 8 * (i / 8) + (i % 8)) : i;
        res[i] = data[src[5:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/usb_tx_stuff_ctr.sv
// Consecutive-ones counter that decides when a stuff zero must go on the line.
module usb_tx_stuff_ctr
  import usb_tx_pkg::*;
#(
  parameter bit STUFF_EN = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic adv,
  input  logic data_bit,
  input  logic clear,
  output logic stuff_now
);

  logic [2:0] ones_cnt_reg;

  assign stuff_now = STUFF_EN && (ones_cnt_reg == 3'(STUFF_LIMIT));

  // Count ones emitted on the line; a stuff zero or a data zero restarts the run.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt_reg <= '0;
    end else if (clear) begin
      ones_cnt_reg <= '0;
    end else if (adv) begin
      if (stuff_now || !data_bit) begin
        ones_cnt_reg <= '0;
      end else if (ones_cnt_reg != 3'(STUFF_LIMIT)) begin
        ones_cnt_reg <= ones_cnt_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: word handshake in, stuffed serial bit stream out,
// with an optional CRC appended after the last data word.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int WORD_W         = 16,
  parameter int CRC_W          = 16,
  parameter bit CRC_EN         = 1'b1,
  parameter bit STUFF_EN       = 1'b1,
  parameter bit MSB_BYTE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_enable,
  input  logic              tx_shift,
  input  logic              tx_hold,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_last,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              tx_bit,
  output logic              stuff_bit,
  output logic              busy,
  output logic              pkt_done,
  output logic              tx_underrun
);

  localparam int SR_W  = (WORD_W > CRC_W) ? WORD_W : CRC_W;
  localparam int CNT_W = $clog2(SR_W + 1);

  // What the current bit period does; decided combinationally, applied in the FSM.
  typedef enum logic [2:0] {
    ST_NONE, ST_STUFF, ST_START, ST_SHIFT, ST_NEXT, ST_CRC_LOAD, ST_DONE, ST_UNDERRUN
  } step_t;

  tx_state_t         state_reg;
  logic [WORD_W-1:0] hold_reg;
  logic              hold_last_reg;
  logic              hold_full_reg;
  logic              cur_last_reg;
  logic [SR_W-1:0]   sr_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic              tx_bit_reg;
  logic              stuff_bit_reg;
  logic              pkt_done_reg;
  logic              underrun_reg;

  logic              adv;
  logic              accept;
  logic              end_of_pkt;
  logic [SR_W-1:0]   hold_ord;
  logic [SR_W-1:0]   crc_ord;
  step_t             step;
  logic              emit_bit;
  logic              stuff_now;
  logic              ctr_adv;
  logic              ctr_clear;

  assign adv        = tx_enable && tx_shift && !tx_hold;
  assign accept     = word_valid && !hold_full_reg;
  assign hold_ord   = SR_W'(bit_reorder(64'(hold_reg), WORD_W, MSB_BYTE_FIRST));
  assign crc_ord    = SR_W'(bit_reorder(64'(crc_in), CRC_W, MSB_BYTE_FIRST));
  assign end_of_pkt = (state_reg == CRC) || (state_reg == DATA && cur_last_reg && !CRC_EN);

  assign word_ready  = !hold_full_reg;
  assign busy        = (state_reg != IDLE);
  assign tx_bit      = tx_bit_reg;
  assign stuff_bit   = stuff_bit_reg;
  assign pkt_done    = pkt_done_reg;
  assign tx_underrun = underrun_reg;

  // Pick this bit period's action; a pending stuff bit always wins over data.
  always_comb begin
    step     = ST_NONE;
    emit_bit = IDLE_BIT;
    if (adv) begin
      case (state_reg)
        IDLE: begin
          if (hold_full_reg) begin
            step     = ST_START;
            emit_bit = hold_ord[0];
          end
        end
        DATA, CRC: begin
          if (stuff_now) begin
            step     = ST_STUFF;
            emit_bit = 1'b0;
          end else if (rem_reg != '0) begin
            step     = ST_SHIFT;
            emit_bit = sr_reg[0];
          end else if (state_reg == DATA && !cur_last_reg && hold_full_reg) begin
            step     = ST_NEXT;
            emit_bit = hold_ord[0];
          end else if (state_reg == DATA && !cur_last_reg) begin
            step     = ST_UNDERRUN;
          end else if (state_reg == DATA && CRC_EN) begin
            step     = ST_CRC_LOAD;
            emit_bit = crc_ord[0];
          end else begin
            step     = ST_DONE;
          end
        end
        FLUSH: begin
          if (stuff_now) begin
            step     = ST_STUFF;
            emit_bit = 1'b0;
          end else begin
            step     = ST_DONE;
          end
        end
        default: step = ST_NONE;
      endcase
    end
  end

  // Ones run tracks every emitted line bit and restarts whenever the line goes idle.
  always_comb begin
    ctr_adv   = (step == ST_STUFF) || (step == ST_START) || (step == ST_SHIFT) ||
                (step == ST_NEXT) || (step == ST_CRC_LOAD);
    ctr_clear = (step == ST_DONE) || (step == ST_UNDERRUN) ||
                (state_reg == IDLE && step != ST_START);
  end

  usb_tx_stuff_ctr #(
    .STUFF_EN (STUFF_EN)
  ) u_stuff_ctr (
    .clk       (clk),
    .n_rst     (n_rst),
    .adv       (ctr_adv),
    .data_bit  (emit_bit),
    .clear     (ctr_clear),
    .stuff_now (stuff_now)
  );

  // Main FSM with holding buffer, shift register and registered line outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      hold_last_reg <= 1'b0;
      hold_full_reg <= 1'b0;
      cur_last_reg  <= 1'b0;
      sr_reg        <= '0;
      rem_reg       <= '0;
      tx_bit_reg    <= IDLE_BIT;
      stuff_bit_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      pkt_done_reg <= 1'b0;
      underrun_reg <= 1'b0;

      if (accept) begin
        hold_reg      <= word_in;
        hold_last_reg <= word_last;
      end

      // Accept only happens when empty, consume only when full, so they never collide.
      if (step == ST_START || step == ST_NEXT) begin
        hold_full_reg <= 1'b0;
      end else if (accept) begin
        hold_full_reg <= 1'b1;
      end

      case (step)
        ST_START, ST_NEXT: begin
          sr_reg        <= hold_ord >> 1;
          rem_reg       <= CNT_W'(WORD_W - 1);
          cur_last_reg  <= hold_last_reg;
          tx_bit_reg    <= emit_bit;
          stuff_bit_reg <= 1'b0;
          state_reg     <= DATA;
        end
        ST_CRC_LOAD: begin
          sr_reg        <= crc_ord >> 1;
          rem_reg       <= CNT_W'(CRC_W - 1);
          tx_bit_reg    <= emit_bit;
          stuff_bit_reg <= 1'b0;
          state_reg     <= CRC;
        end
        ST_SHIFT: begin
          sr_reg        <= sr_reg >> 1;
          rem_reg       <= rem_reg - CNT_W'(1);
          tx_bit_reg    <= emit_bit;
          stuff_bit_reg <= 1'b0;
        end
        ST_STUFF: begin
          tx_bit_reg    <= 1'b0;
          stuff_bit_reg <= 1'b1;
          // A stuff bit after the final packet bit leaves only the closing idle step.
          if (rem_reg == '0 && end_of_pkt) begin
            state_reg <= FLUSH;
          end
        end
        ST_DONE: begin
          tx_bit_reg    <= IDLE_BIT;
          stuff_bit_reg <= 1'b0;
          pkt_done_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        ST_UNDERRUN: begin
          tx_bit_reg    <= IDLE_BIT;
          stuff_bit_reg <= 1'b0;
          underrun_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: one CRC-enabled and one CRC-less instance.
module tb_usb_tx_serializer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        tx_enable = 1'b1;
  logic        tx_shift = 1'b0;
  logic        tx_hold = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_last = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] crc_in = '0;

  logic ready_c, bit_c, stuff_c, busy_c, done_c, ur_c;
  logic ready_n, bit_n, stuff_n, busy_n, done_n, ur_n;

  logic sel_n = 1'b0;
  logic o_ready, o_bit, o_stuff, o_busy, o_done, o_ur;

  logic s_ready, s_bit, s_stuff, s_busy, s_done, s_ur, s_done2, s_ur2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_tx_serializer #(
    .WORD_W(16), .CRC_W(16), .CRC_EN(1'b1), .STUFF_EN(1'b1), .MSB_BYTE_FIRST(1'b1)
  ) dut_crc (
    .clk(clk), .n_rst(n_rst), .tx_enable(tx_enable), .tx_shift(tx_shift), .tx_hold(tx_hold),
    .word_in(word_in), .word_last(word_last), .word_valid(word_valid), .word_ready(ready_c),
    .crc_in(crc_in), .tx_bit(bit_c), .stuff_bit(stuff_c), .busy(busy_c),
    .pkt_done(done_c), .tx_underrun(ur_c)
  );

  usb_tx_serializer #(
    .WORD_W(16), .CRC_W(16), .CRC_EN(1'b0), .STUFF_EN(1'b1), .MSB_BYTE_FIRST(1'b1)
  ) dut_nocrc (
    .clk(clk), .n_rst(n_rst), .tx_enable(tx_enable), .tx_shift(tx_shift), .tx_hold(tx_hold),
    .word_in(word_in), .word_last(word_last), .word_valid(word_valid), .word_ready(ready_n),
    .crc_in(crc_in), .tx_bit(bit_n), .stuff_bit(stuff_n), .busy(busy_n),
    .pkt_done(done_n), .tx_underrun(ur_n)
  );

  assign o_ready = sel_n ? ready_n : ready_c;
  assign o_bit   = sel_n ? bit_n   : bit_c;
  assign o_stuff = sel_n ? stuff_n : stuff_c;
  assign o_busy  = sel_n ? busy_n  : busy_c;
  assign o_done  = sel_n ? done_n  : done_c;
  assign o_ur    = sel_n ? ur_n    : ur_c;

  // One bit period of 4 clocks; outputs sampled on the negedge right after the strobe edge.
  task automatic strobe();
    @(negedge clk); tx_shift = 1'b1;
    @(negedge clk); tx_shift = 1'b0;
    s_ready = o_ready; s_bit = o_bit; s_stuff = o_stuff;
    s_busy = o_busy; s_done = o_done; s_ur = o_ur;
    @(negedge clk);
    s_done2 = o_done; s_ur2 = o_ur;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] w, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready word=%h actual=%b required=1", w, o_ready);
    end
    word_in = w; word_last = last; word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bit_c, stuff_c, busy_c, done_c, ur_c, ready_c} !== 6'b100001) begin
      errors++;
      $display("FAIL reset_crc actual=%b required=100001", {bit_c, stuff_c, busy_c, done_c, ur_c, ready_c});
    end
    checks++;
    if ({bit_n, stuff_n, busy_n, done_n, ur_n, ready_n} !== 6'b100001) begin
      errors++;
      $display("FAIL reset_nocrc actual=%b required=100001", {bit_n, stuff_n, busy_n, done_n, ur_n, ready_n});
    end
    n_rst = 1'b1;
    @(negedge clk);
    $display("reset: checked both instances");
  endtask

  task automatic test_single_word();
    logic [0:15] e;
    e = 16'b1010_0101_1000_0000;
    sel_n = 1'b1;
    apply_reset();
    crc_in = 16'h0000;
    push_word(16'hA501, 1'b1);
    for (int i = 0; i < 16; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_stuff, s_done, s_busy} !== {e[i], 3'b001}) begin
        errors++;
        $display("FAIL single_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff, s_done, s_busy}, {e[i], 3'b001});
      end
    end
    strobe();
    checks++;
    if ({s_bit, s_done, s_ur, s_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL single_end actual=%b required=1100", {s_bit, s_done, s_ur, s_busy});
    end
    checks++;
    if (s_done2 !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width actual=%b required=0", s_done2);
    end
    sel_n = 1'b0;
    $display("single_word: A501 sent without CRC");
  endtask

  task automatic test_stuffing();
    logic [0:33] e;
    logic [0:33] m;
    e = 34'b111111_0_111111_0_1111_0000000000000000;
    m = 34'b000000_1_000000_1_0000_0000000000000000;
    apply_reset();
    crc_in = 16'h0000;
    push_word(16'hFFFF, 1'b1);
    for (int i = 0; i < 34; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_stuff, s_done} !== {e[i], m[i], 1'b0}) begin
        errors++;
        $display("FAIL stuff_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff, s_done}, {e[i], m[i], 1'b0});
      end
    end
    strobe();
    checks++;
    if ({s_bit, s_stuff, s_done, s_busy} !== 4'b1010) begin
      errors++;
      $display("FAIL stuff_end actual=%b required=1010", {s_bit, s_stuff, s_done, s_busy});
    end
    $display("stuffing: FFFF plus zero CRC, 34 periods");
  endtask

  task automatic test_back_to_back();
    logic [0:31] e;
    e = 32'b01001000_00101100_01101010_00011110;
    apply_reset();
    crc_in = 16'h0000;
    push_word(16'h1234, 1'b0);
    strobe();
    checks++;
    if ({s_bit, s_ready, s_busy} !== {e[0], 2'b11}) begin
      errors++;
      $display("FAIL b2b_first actual=%b required=%b", {s_bit, s_ready, s_busy}, {e[0], 2'b11});
    end
    push_word(16'h5678, 1'b1);
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold_full actual=%b required=0", o_ready);
    end
    for (int i = 1; i < 32; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_stuff, s_busy, s_done, s_ur} !== {e[i], 4'b0100}) begin
        errors++;
        $display("FAIL b2b_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff, s_busy, s_done, s_ur}, {e[i], 4'b0100});
      end
      if (i == 15 || i == 16) begin
        checks++;
        if (s_ready !== (i == 16)) begin
          errors++;
          $display("FAIL b2b_ready[%0d] actual=%b required=%b", i, s_ready, (i == 16));
        end
      end
    end
    $display("back_to_back: 1234,5678 contiguous");
  endtask

  task automatic test_underrun();
    logic [0:15] e;
    e = 16'b01001000_00101100;
    apply_reset();
    push_word(16'h1234, 1'b0);
    for (int i = 0; i < 16; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_ur} !== {e[i], 1'b0}) begin
        errors++;
        $display("FAIL underrun_bit[%0d] actual=%b required=%b", i, {s_bit, s_ur}, {e[i], 1'b0});
      end
    end
    strobe();
    checks++;
    if ({s_bit, s_busy, s_done, s_ur} !== 4'b1001) begin
      errors++;
      $display("FAIL underrun_end actual=%b required=1001", {s_bit, s_busy, s_done, s_ur});
    end
    checks++;
    if ({s_ur2, s_done2} !== 2'b00) begin
      errors++;
      $display("FAIL underrun_width actual=%b required=00", {s_ur2, s_done2});
    end
    $display("underrun: aborted after 16 bits");
  endtask

  task automatic hold_phase(input logic eb, input logic es);
    tx_hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tx_shift = (c % 3 == 0);
      checks++;
      if ({o_bit, o_stuff, o_busy} !== {eb, es, 1'b1}) begin
        errors++;
        $display("FAIL hold_freeze[%0d] actual=%b required=%b", c, {o_bit, o_stuff, o_busy}, {eb, es, 1'b1});
      end
    end
    tx_shift = 1'b0;
    tx_hold = 1'b0;
  endtask

  task automatic test_hold();
    logic [0:33] e;
    logic [0:33] m;
    e = 34'b111111_0_111111_0_1111_0000000000000000;
    m = 34'b000000_1_000000_1_0000_0000000000000000;
    apply_reset();
    crc_in = 16'h0000;
    push_word(16'hFFFF, 1'b1);
    for (int i = 0; i < 34; i++) begin
      if (i == 3 || i == 6) hold_phase(e[i-1], m[i-1]);
      strobe();
      checks++;
      if ({s_bit, s_stuff} !== {e[i], m[i]}) begin
        errors++;
        $display("FAIL hold_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff}, {e[i], m[i]});
      end
    end
    strobe();
    checks++;
    if ({s_bit, s_done} !== 2'b11) begin
      errors++;
      $display("FAIL hold_end actual=%b required=11", {s_bit, s_done});
    end
    $display("hold: stalls mid-word and on pending stuff");
  endtask

  task automatic test_reset_mid_crc();
    logic [0:32] e;
    logic [0:32] m;
    e = 33'b111111_0_10_00000000_0000000000000000;
    m = 33'b000000_1_00_00000000_0000000000000000;
    apply_reset();
    crc_in = 16'hFFFF;
    push_word(16'h0000, 1'b1);
    for (int i = 0; i < 21; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_stuff} !== {(i >= 16), 1'b0}) begin
        errors++;
        $display("FAIL midcrc_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff}, {(i >= 16), 1'b0});
      end
    end
    push_word(16'h1111, 1'b1);
    checks++;
    if ({o_ready, o_busy} !== 2'b01) begin
      errors++;
      $display("FAIL midcrc_held actual=%b required=01", {o_ready, o_busy});
    end
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({o_bit, o_stuff, o_busy, o_done, o_ur, o_ready} !== 6'b100001) begin
      errors++;
      $display("FAIL midcrc_reset actual=%b required=100001", {o_bit, o_stuff, o_busy, o_done, o_ur, o_ready});
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    crc_in = 16'h0000;
    push_word(16'h7F00, 1'b1);
    for (int i = 0; i < 33; i++) begin
      strobe();
      checks++;
      if ({s_bit, s_stuff} !== {e[i], m[i]}) begin
        errors++;
        $display("FAIL fresh_bit[%0d] actual=%b required=%b", i, {s_bit, s_stuff}, {e[i], m[i]});
      end
    end
    strobe();
    checks++;
    if ({s_bit, s_done} !== 2'b11) begin
      errors++;
      $display("FAIL fresh_end actual=%b required=11", {s_bit, s_done});
    end
    $display("reset_mid_crc: fresh 7F00 packet after reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single_word();
    test_stuffing();
    test_back_to_back();
    test_underrun();
    test_hold();
    test_reset_mid_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
